// File: rtl/fifo_out_drain_arb_if.sv
// Handshake bundle between the output-bridge FIFO bank, the drain arbiter and the core writeback port.
// master: the arbiter; slave: the FIFO bank / core side.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface fifo_out_drain_arb_if #(
  parameter int NUM_PORTS = 5,
  parameter int ID_WIDTH  = 3
);
  localparam int WORD_W = `DATA_WIDTH + 1;

  logic [NUM_PORTS-1:0]        fifo_empty;
  logic [NUM_PORTS-1:0]        fifo_valid;
  logic [NUM_PORTS*WORD_W-1:0] fifo_dout;
  logic [NUM_PORTS-1:0]        fifo_deq;
  logic [WORD_W-1:0]           core_data;
  logic [ID_WIDTH-1:0]         core_id;
  logic                        core_valid;
  logic                        core_ready;
  logic [NUM_PORTS-1:0]        grant;

  modport master (
    input  fifo_empty, fifo_valid, fifo_dout, core_ready,
    output fifo_deq, core_data, core_id, core_valid, grant
  );

  modport slave (
    output fifo_empty, fifo_valid, fifo_dout, core_ready,
    input  fifo_deq, core_data, core_id, core_valid, grant
  );
endinterface

// File: rtl/fifo_out_drain_arb.sv
// Round-robin burst drain of NUM_PORTS output FIFOs onto one registered, id-tagged core port.
// Optional per-port delivered-word counters are enabled by defining DRAIN_STATS_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module fifo_out_drain_arb #(
  parameter int NUM_PORTS = 5,
  parameter int ID_WIDTH  = 3,
  parameter int BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_out_drain_arb_if.master  bus,
  input  logic [ID_WIDTH-1:0]   stat_sel,
  output logic [15:0]           stat_count
);
  localparam int WORD_W = `DATA_WIDTH + 1;
  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t                 state_r;
  logic [ID_WIDTH-1:0]    last_r;
  logic [ID_WIDTH-1:0]    gidx_r;
  logic [NUM_PORTS-1:0]   grant_r;
  logic [3:0]             burst_r;
  logic [WORD_W-1:0]      core_data_r;
  logic [ID_WIDTH-1:0]    core_id_r;
  logic                   core_valid_r;

  logic                   out_free_s;
  logic                   sel_empty_s;
  logic                   sel_valid_s;
  logic [WORD_W-1:0]      sel_data_s;
  logic                   found_s;
  logic [ID_WIDTH-1:0]    found_idx_s;
  logic [ID_WIDTH-1:0]    cand_s;
  logic [NUM_PORTS-1:0]   deq_s;
  logic                   load_s;

  // Select the granted FIFO's status/data and find the next non-empty port after last_r.
  always_comb begin
    sel_empty_s = 1'b1;
    sel_valid_s = 1'b0;
    sel_data_s  = '0;
    found_s     = 1'b0;
    found_idx_s = '0;
    cand_s      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_empty_s = (gidx_r == ID_WIDTH'(i)) ? bus.fifo_empty[i] : sel_empty_s;
      sel_valid_s = (gidx_r == ID_WIDTH'(i)) ? bus.fifo_valid[i] : sel_valid_s;
      sel_data_s  = (gidx_r == ID_WIDTH'(i)) ? bus.fifo_dout[i*WORD_W +: WORD_W] : sel_data_s;
    end
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand_s      = ID_WIDTH'((int'(last_r) + k) % NUM_PORTS);
      found_idx_s = (!found_s && !bus.fifo_empty[cand_s]) ? cand_s : found_idx_s;
      found_s     = found_s | ~bus.fifo_empty[cand_s];
    end
  end

  // Dequeue only into a free output slot; the reset cycle never dequeues.
  always_comb begin
    out_free_s = ~core_valid_r | bus.core_ready;
    if (!rst && state_r == DRAIN && out_free_s && !sel_empty_s) begin
      deq_s = grant_r;
    end else begin
      deq_s = '0;
    end
    load_s = (|deq_s) & sel_valid_s;
  end

  // Arbitration state machine and registered core-side output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_r       <= ID_WIDTH'(NUM_PORTS - 1);
      gidx_r       <= '0;
      grant_r      <= '0;
      burst_r      <= 4'd0;
      core_data_r  <= '0;
      core_id_r    <= '0;
      core_valid_r <= 1'b0;
    end else begin
      if (load_s) begin
        core_data_r  <= sel_data_s;
        core_id_r    <= gidx_r;
        core_valid_r <= 1'b1;
      end else if (bus.core_ready) begin
        core_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant_r <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << found_idx_s;
            gidx_r  <= found_idx_s;
            burst_r <= 4'd0;
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (load_s) begin
            burst_r <= burst_r + 4'd1;
          end
          if ((load_s && (burst_r + 4'd1 == BURST_LIM)) || (sel_empty_s && out_free_s)) begin
            state_r <= IDLE;
            last_r  <= gidx_r;
            grant_r <= '0;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
        end
      endcase
    end
  end

  assign bus.fifo_deq   = deq_s;
  assign bus.core_data  = core_data_r;
  assign bus.core_id    = core_id_r;
  assign bus.core_valid = core_valid_r;
  assign bus.grant      = grant_r;

`ifdef DRAIN_STATS_EN
  logic [15:0] cnt_r [NUM_PORTS];
  logic [15:0] stat_r;
  logic [15:0] sel_cnt_s;

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_cnt_s = 16'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_cnt_s = (stat_sel == ID_WIDTH'(i)) ? cnt_r[i] : sel_cnt_s;
    end
  end

  // Saturating per-port counters of accepted core words, plus registered readout.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_r[i] <= 16'd0;
      end
      stat_r <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (core_valid_r && bus.core_ready && core_id_r == ID_WIDTH'(i) && cnt_r[i] != 16'hFFFF) begin
          cnt_r[i] <= cnt_r[i] + 16'd1;
        end
      end
      stat_r <= sel_cnt_s;
    end
  end

  assign stat_count = stat_r;
`else
  logic unused_stat_sel_s;
  assign unused_stat_sel_s = ^stat_sel;
  assign stat_count = 16'd0;
`endif

endmodule
